dht_ascii_formatter: RTL
========================

DHT_ASCII_FORMATTER -- requirements
Module: dht_ascii_formatter

Interface
REQ-001 Parameter SEND_CRLF, default 1: when 1, every message ends with 0x0D 0x0A; when 0, no terminator is sent.
REQ-002 CLK  input  1  system clock (25 MHz); the transmitter handshake is synchronous to CLK.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 sample_valid  input  1  single-cycle pulse from the DHT11 acquisition stage announcing a new sample.
REQ-005 sample_error  input  1  checksum-failure flag, qualified by sample_valid.
REQ-006 rh  input  8  relative humidity byte, qualified by sample_valid.
REQ-007 temp  input  8  temperature byte, qualified by sample_valid.
REQ-008 tx_ready  input  1  UART transmitter idle/accepting, level signal.
REQ-009 tx_byte  output  8  ASCII byte presented to the UART transmitter.
REQ-010 tx_start  output  1  single-cycle request to transmit tx_byte.
REQ-011 busy  output  1  high from capture until the last byte is acknowledged.
REQ-012 overrun  output  1  single-cycle pulse when sample_valid arrives while busy.

Function
REQ-013 Normal message, fixed width with leading zeros: "H=ddd T=ddd" (11 bytes), followed by CR LF if SEND_CRLF=1 (13 bytes total).
REQ-014 Error message, sent when sample_error=1 at capture: "ERR" (3 bytes), followed by CR LF if SEND_CRLF=1; rh and temp are ignored.
REQ-015 Capture: on a CLK edge with sample_valid=1 in IDLE, latch rh, temp and sample_error; busy=1 from the next cycle.
REQ-016 States: IDLE, CONV, LOAD, WAIT_LOW, WAIT_HIGH.
  - IDLE -> CONV on a normal capture.
  - IDLE -> LOAD on an error capture.
  - CONV -> LOAD after exactly 8 cycles.
  - LOAD -> WAIT_LOW, asserting tx_start, when tx_ready=1.
  - WAIT_LOW -> WAIT_HIGH when tx_ready=0.
  - WAIT_HIGH -> LOAD (next byte) or -> IDLE (last byte) when tx_ready=1.
REQ-017 Conversion: rh and temp are converted in parallel by shift-and-add-3, one bit per cycle, 8 cycles; result is 3 BCD digits (hundreds 0-2).
REQ-018 Digit encoding: byte = 0x30 + BCD digit; no other arithmetic on the output path.
REQ-019 Latency, normal path: sample_valid sampled at cycle 0, CONV during cycles 1-8, first tx_start at cycle 9 if tx_ready=1 (later cycles if not).
REQ-020 Latency, error path: first tx_start at cycle 1 if tx_ready=1.
REQ-021 tx_byte is valid in the tx_start cycle and stays stable until the next tx_start.
REQ-022 tx_start is never high on two consecutive cycles.
REQ-023 No new tx_start is issued until tx_ready has been seen low and then high again.
REQ-024 tx_ready held low stalls the block indefinitely, with no byte loss and no timeout.
REQ-025 sample_valid while busy=1: the sample is discarded, overrun pulses, and the message in progress is unaffected.
REQ-026 sample_valid on the cycle busy falls: that cycle counts as IDLE and the sample is captured.
REQ-027 Byte index counter wraps only by returning to IDLE; it never exceeds message length minus 1.

Reset
REQ-028 RESET=1 forces IDLE immediately: tx_byte=0x00, tx_start=0, busy=0, overrun=0, latched data and BCD cleared.
REQ-029 Reset mid-message abandons the message; no partial continuation after release.
REQ-030 First capture is possible on the first CLK edge after RESET deasserts.

Structure
REQ-031 Shared package dht_fmt_pkg holds:
  - state encoding
  - ASCII constants ('H', 'T', '=', ' ', 'E', 'R', CR, LF, '0')
  - message length constants for normal/error, with and without CRLF
REQ-032 Sub-module bcd_conv8 (start, 8-bit binary in, done, 12-bit BCD out) is instantiated twice.
REQ-033 Byte selection is a combinational mux indexed by the byte counter and the error flag.

Verification
REQ-034 rh=45, temp=23, tx_ready model with 10-cycle busy -> 48 3D 30 34 35 20 54 3D 30 32 33 0D 0A in order, then busy=0.
REQ-035 rh=255, temp=0, SEND_CRLF=0 -> "H=255 T=000", 11 bytes, no CR LF.
REQ-036 sample_error=1, rh=99 -> 45 52 52 0D 0A; first tx_start exactly 1 cycle after sample_valid.
REQ-037 Second sample_valid at byte 4 -> overrun pulses once, first message completes intact, second sample is never sent.
REQ-038 Assert RESET during byte 6, release it, send rh=7, temp=8 -> outputs reset immediately, then a clean "H=007 T=008\r\n".
REQ-039 Hold tx_ready=0 for 1000 cycles mid-message -> no tx_start during the stall; the remaining bytes follow correctly once tx_ready rises.

Source files
------------

// File: rtl/dht_fmt_pkg.sv
// Shared constants for the DHT11 ASCII formatter: FSM encoding, ASCII codes
// and message lengths.
package dht_fmt_pkg;

  typedef logic [7:0] ascii_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CONV      = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  localparam ascii_t ASC_H  = 8'h48;
  localparam ascii_t ASC_T  = 8'h54;
  localparam ascii_t ASC_EQ = 8'h3D;
  localparam ascii_t ASC_SP = 8'h20;
  localparam ascii_t ASC_E  = 8'h45;
  localparam ascii_t ASC_R  = 8'h52;
  localparam ascii_t ASC_CR = 8'h0D;
  localparam ascii_t ASC_LF = 8'h0A;
  localparam ascii_t ASC_0  = 8'h30;

  localparam int LEN_NORM      = 11;
  localparam int LEN_NORM_CRLF = 13;
  localparam int LEN_ERR       = 3;
  localparam int LEN_ERR_CRLF  = 5;

  function automatic ascii_t bcd_to_ascii(input logic [3:0] d);
    return ASC_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/dht_ascii_formatter_if.sv
// Sample input and UART-transmitter handshake bundle of the formatter.
// tx_start is a one-cycle request qualified by tx_ready; the transmitter
// acknowledges by dropping tx_ready and raising it again when done.
interface dht_ascii_formatter_if;
  logic       sample_valid;
  logic       sample_error;
  logic [7:0] rh;
  logic [7:0] temp;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       busy;
  logic       overrun;

  modport slave (
    input  sample_valid, sample_error, rh, temp, tx_ready,
    output tx_byte, tx_start, busy, overrun
  );

  modport master (
    output sample_valid, sample_error, rh, temp, tx_ready,
    input  tx_byte, tx_start, busy, overrun
  );
endinterface

// File: rtl/bcd_conv8.sv
// 8-bit binary to 3-digit BCD, shift-and-add-3, one bit per cycle.
// o_done is high during the cycle whose closing edge makes o_bcd final.
module bcd_conv8 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_done,
  output logic [11:0] o_bcd
);
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [3:0]  w_d0;
  logic [3:0]  w_d1;

  // Hundreds never exceeds 2 for an 8-bit input, so it needs no correction.
  always_comb begin
    w_d0 = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    w_d1 = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= 4'd8;
    end else if (r_cnt != 4'd0) begin
      r_bcd <= {r_bcd[10:8], w_d1, w_d0, r_bin[7]};
      r_bin <= {r_bin[6:0], 1'b0};
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd1);
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/dht_ascii_formatter.sv
// Formats DHT11 samples as "H=ddd T=ddd" or "ERR" (optionally + CR LF) and
// feeds them byte by byte to a UART transmitter.
module dht_ascii_formatter
  import dht_fmt_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dht_ascii_formatter_if.slave  bus,
  output logic [2:0]            o_state
);
  localparam logic [3:0] LAST_NORM = SEND_CRLF ? 4'(LEN_NORM_CRLF - 1) : 4'(LEN_NORM - 1);
  localparam logic [3:0] LAST_ERR  = SEND_CRLF ? 4'(LEN_ERR_CRLF - 1)  : 4'(LEN_ERR - 1);

  logic [2:0]  r_state;
  logic        r_err;
  logic [3:0]  r_idx;
  logic [7:0]  r_hold;

  logic        w_idle;
  logic        w_start_conv;
  logic        w_done_rh;
  logic        w_done_t;
  logic [11:0] w_bcd_rh;
  logic [11:0] w_bcd_t;
  logic [3:0]  w_last;
  logic        w_tx_start;
  ascii_t      w_byte;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_start_conv = w_idle && bus.sample_valid && !bus.sample_error;
  assign w_last       = r_err ? LAST_ERR : LAST_NORM;
  assign w_tx_start   = (r_state == ST_LOAD) && bus.tx_ready;

  // The converters latch rh/temp themselves on the capture edge.
  bcd_conv8 u_conv_rh (
    .CLK(CLK), .RESET(RESET), .i_start(w_start_conv), .i_bin(bus.rh),
    .o_done(w_done_rh), .o_bcd(w_bcd_rh)
  );

  bcd_conv8 u_conv_t (
    .CLK(CLK), .RESET(RESET), .i_start(w_start_conv), .i_bin(bus.temp),
    .o_done(w_done_t), .o_bcd(w_bcd_t)
  );

  always_comb begin
    w_byte = 8'h00;
    if (r_err) begin
      case (r_idx)
        4'd0: w_byte = ASC_E;
        4'd1: w_byte = ASC_R;
        4'd2: w_byte = ASC_R;
        4'd3: w_byte = ASC_CR;
        4'd4: w_byte = ASC_LF;
        default: w_byte = 8'h00;
      endcase
    end else begin
      case (r_idx)
        4'd0:  w_byte = ASC_H;
        4'd1:  w_byte = ASC_EQ;
        4'd2:  w_byte = bcd_to_ascii(w_bcd_rh[11:8]);
        4'd3:  w_byte = bcd_to_ascii(w_bcd_rh[7:4]);
        4'd4:  w_byte = bcd_to_ascii(w_bcd_rh[3:0]);
        4'd5:  w_byte = ASC_SP;
        4'd6:  w_byte = ASC_T;
        4'd7:  w_byte = ASC_EQ;
        4'd8:  w_byte = bcd_to_ascii(w_bcd_t[11:8]);
        4'd9:  w_byte = bcd_to_ascii(w_bcd_t[7:4]);
        4'd10: w_byte = bcd_to_ascii(w_bcd_t[3:0]);
        4'd11: w_byte = ASC_CR;
        4'd12: w_byte = ASC_LF;
        default: w_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_hold  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.sample_valid) begin
            r_err   <= bus.sample_error;
            r_idx   <= '0;
            r_state <= bus.sample_error ? ST_LOAD : ST_CONV;
          end
        end
        ST_CONV: begin
          if (w_done_rh && w_done_t) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (bus.tx_ready) begin
            r_hold  <= w_byte;
            r_state <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!bus.tx_ready) r_state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (bus.tx_ready) begin
            if (r_idx == w_last) begin
              r_idx   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= ST_LOAD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // tx_byte switches to the new byte exactly in the tx_start cycle and is
  // held from then on, so it never moves between requests.
  assign bus.tx_start = w_tx_start;
  assign bus.tx_byte  = w_tx_start ? w_byte : r_hold;
  assign bus.busy     = !w_idle;
  assign bus.overrun  = bus.sample_valid && !w_idle;
  assign o_state      = r_state;
endmodule
